// File: rtl/alu_share_arbiter_if.sv
// Bundle of the two requester channels, the shared ALU datapath and the response channel
// seen by alu_share_arbiter. The arbiter connects through the slave modport.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 4,
    parameter int SEL_W = 3
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [SEL_W-1:0] req0_s;
    logic             req0_cin;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [SEL_W-1:0] req1_s;
    logic             req1_cin;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [SEL_W-1:0] alu_s;
    logic             alu_cin;
    logic [WIDTH-1:0] alu_y;
    logic [WIDTH-1:0] alu_cout;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_y;
    logic [WIDTH-1:0] rsp_cout;

    // Environment side: requesters, the ALU itself and the response consumer
    modport master (
        output req0_valid, req0_a, req0_b, req0_s, req0_cin,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_s, req1_cin,
        input  req1_ready,
        input  alu_a, alu_b, alu_s, alu_cin,
        output alu_y, alu_cout,
        input  rsp_valid, rsp_id, rsp_y, rsp_cout,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_s, req0_cin,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_s, req1_cin,
        output req1_ready,
        output alu_a, alu_b, alu_s, alu_cin,
        input  alu_y, alu_cout,
        output rsp_valid, rsp_id, rsp_y, rsp_cout,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters: register the
// winner's operands, hold them for a settle time, capture the result and return it.
module alu_share_arbiter #(
    parameter int WIDTH         = 4,
    parameter int SEL_W         = 3,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    alu_share_arbiter_if.slave  bus,
    output logic                busy,
    output logic [7:0]          op_count
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic             last_grant;
    logic             grant;
    logic             any_valid;
    logic [3:0]       settle_cnt;

    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [SEL_W-1:0] alu_s_q;
    logic             alu_cin_q;
    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_y_q;
    logic [WIDTH-1:0] rsp_cout_q;

    // On a tie the requester that was not served last wins
    always_comb begin
        any_valid = bus.req0_valid | bus.req1_valid;
        grant     = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_grant;
        end else if (bus.req1_valid) begin
            grant = 1'b1;
        end
    end

    assign bus.req0_ready = (state == IDLE) && bus.req0_valid && !grant;
    assign bus.req1_ready = (state == IDLE) && bus.req1_valid &&  grant;
    assign busy           = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_valid)                state_nxt = EXEC;
            EXEC:    if (settle_cnt == 4'd0)       state_nxt = RESP;
            RESP:    if (bus.rsp_ready)            state_nxt = IDLE;
            default:                               state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operands stay on the ALU after completion; only an accept replaces them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_s_q     <= '0;
            alu_cin_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_y_q     <= '0;
            rsp_cout_q  <= '0;
            last_grant  <= 1'b1;
            settle_cnt  <= 4'd0;
            op_count    <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        alu_a_q    <= grant ? bus.req1_a   : bus.req0_a;
                        alu_b_q    <= grant ? bus.req1_b   : bus.req0_b;
                        alu_s_q    <= grant ? bus.req1_s   : bus.req0_s;
                        alu_cin_q  <= grant ? bus.req1_cin : bus.req0_cin;
                        rsp_id_q   <= grant;
                        settle_cnt <= SETTLE_LOAD;
                    end
                end
                EXEC: begin
                    if (settle_cnt == 4'd0) begin
                        rsp_y_q     <= bus.alu_y;
                        rsp_cout_q  <= bus.alu_cout;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        last_grant  <= rsp_id_q;
                        op_count    <= op_count + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_s     = alu_s_q;
    assign bus.alu_cin   = alu_cin_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_y     = rsp_y_q;
    assign bus.rsp_cout  = rsp_cout_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: two instances (settle 1 and settle 3) share one stimulus,
// each checked every cycle against a transaction-level model plus literal expectations.
module tb_alu_share_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       v0 = 1'b0, v1 = 1'b0, c0 = 1'b0, c1 = 1'b0, rr = 1'b0;
    logic [3:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [2:0] s0 = '0, s1 = '0;

    int errors = 0;
    int checks = 0;

    logic       o_rv[2];
    logic       o_id[2];
    logic       o_busy[2];
    logic       o_r0[2];
    logic       o_r1[2];
    logic [3:0] o_y[2];
    logic [7:0] o_cnt[2];
    logic [11:0] o_alu[2];

    // Stand-in ALU: returns {cout, y}
    function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                          input logic [2:0] s, input logic cin);
        logic [4:0] t;
        case (s)
            3'd0: begin t = {1'b0, a} + {1'b0, b} + {4'b0, cin}; return {3'b0, t[4], t[3:0]}; end
            3'd1: begin t = {1'b0, a} - {1'b0, b} - {4'b0, cin}; return {3'b0, t[4], t[3:0]}; end
            3'd2: return {4'h0, a & b};
            3'd3: return {4'h0, a | b};
            3'd4: return {4'h0, a ^ b};
            default: return {4'hF, ~a};
        endcase
    endfunction

    task automatic check_output(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g
        localparam int S = (k == 0) ? 1 : 3;

        alu_share_arbiter_if #(.WIDTH(4), .SEL_W(3)) bus ();
        logic       busy;
        logic [7:0] opc;
        logic [7:0] fy;

        assign bus.req0_valid = v0;
        assign bus.req0_a     = a0;
        assign bus.req0_b     = b0;
        assign bus.req0_s     = s0;
        assign bus.req0_cin   = c0;
        assign bus.req1_valid = v1;
        assign bus.req1_a     = a1;
        assign bus.req1_b     = b1;
        assign bus.req1_s     = s1;
        assign bus.req1_cin   = c1;
        assign bus.rsp_ready  = rr;
        assign fy             = alu_fn(bus.alu_a, bus.alu_b, bus.alu_s, bus.alu_cin);
        assign bus.alu_y      = fy[3:0];
        assign bus.alu_cout   = fy[7:4];

        alu_share_arbiter #(.WIDTH(4), .SEL_W(3), .SETTLE_CYCLES(S)) dut (
            .clk      (clk),
            .rst      (rst),
            .bus      (bus),
            .busy     (busy),
            .op_count (opc)
        );

        assign o_rv[k]   = bus.rsp_valid;
        assign o_id[k]   = bus.rsp_id;
        assign o_busy[k] = busy;
        assign o_r0[k]   = bus.req0_ready;
        assign o_r1[k]   = bus.req1_ready;
        assign o_y[k]    = bus.rsp_y;
        assign o_cnt[k]  = opc;
        assign o_alu[k]  = {bus.alu_a, bus.alu_b, bus.alu_s, bus.alu_cin};

        // Transaction model: who owns the ALU, how many cycles remain, pending result
        logic       m_idle, m_rv, m_last, m_id, m_c, pick;
        logic [3:0] m_a, m_b, m_y, m_co;
        logic [2:0] m_s;
        logic [7:0] m_cnt;
        int         m_wait;

        assign pick = (v0 && v1) ? !m_last : v1;

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                m_idle <= 1'b1; m_rv <= 1'b0; m_last <= 1'b1; m_id <= 1'b0;
                m_a <= '0; m_b <= '0; m_s <= '0; m_c <= 1'b0;
                m_y <= '0; m_co <= '0; m_cnt <= '0; m_wait <= 0;
            end else if (m_idle) begin
                if (v0 || v1) begin
                    m_idle <= 1'b0;
                    m_wait <= S;
                    m_id   <= pick;
                    m_a    <= pick ? a1 : a0;
                    m_b    <= pick ? b1 : b0;
                    m_s    <= pick ? s1 : s0;
                    m_c    <= pick ? c1 : c0;
                end
            end else if (!m_rv) begin
                m_wait <= m_wait - 1;
                if (m_wait == 1) begin
                    m_rv <= 1'b1;
                    {m_co, m_y} <= alu_fn(m_a, m_b, m_s, m_c);
                end
            end else if (rr) begin
                m_rv   <= 1'b0;
                m_idle <= 1'b1;
                m_last <= m_id;
                m_cnt  <= m_cnt + 8'd1;
            end
        end

        always @(negedge clk) begin
            if (!rst) begin
                check_output($sformatf("dut%0d busy", k), 16'(busy), 16'(!m_idle));
                check_output($sformatf("dut%0d req0_ready", k), 16'(bus.req0_ready),
                             16'(m_idle && v0 && !pick));
                check_output($sformatf("dut%0d req1_ready", k), 16'(bus.req1_ready),
                             16'(m_idle && v1 && pick));
                check_output($sformatf("dut%0d rsp_valid", k), 16'(bus.rsp_valid), 16'(m_rv));
                check_output($sformatf("dut%0d op_count", k), 16'(opc), 16'(m_cnt));
                check_output($sformatf("dut%0d alu operands", k),
                             16'({bus.alu_a, bus.alu_b, bus.alu_s, bus.alu_cin}),
                             16'({m_a, m_b, m_s, m_c}));
                if (m_rv) begin
                    check_output($sformatf("dut%0d rsp_id", k), 16'(bus.rsp_id), 16'(m_id));
                    check_output($sformatf("dut%0d rsp result", k),
                                 16'({bus.rsp_cout, bus.rsp_y}), 16'({m_co, m_y}));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic nv0, input logic [3:0] na0, input logic [3:0] nb0,
                                  input logic [2:0] ns0, input logic nc0,
                                  input logic nv1, input logic [3:0] na1, input logic [3:0] nb1,
                                  input logic [2:0] ns1, input logic nc1, input logic nrr);
        v0 = nv0; a0 = na0; b0 = nb0; s0 = ns0; c0 = nc0;
        v1 = nv1; a1 = na1; b1 = nb1; s1 = ns1; c1 = nc1;
        rr = nrr;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int i = 0;
        while ((o_busy[0] || o_busy[1]) && i < limit) begin
            tick();
            i++;
        end
        check_output("wait idle", 16'(o_busy[0] | o_busy[1]), 16'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        logic       ids[4];
        logic [3:0] ys[4];
        logic       exp_id[4];
        logic [3:0] exp_y[4];
        exp_id = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_y  = '{4'd3, 4'd4, 4'd3, 4'd4};

        #2 rst = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            check_output($sformatf("reset busy%0d", k), 16'(o_busy[k]), 16'd0);
            check_output($sformatf("reset rsp_valid%0d", k), 16'(o_rv[k]), 16'd0);
            check_output($sformatf("reset alu%0d", k), 16'(o_alu[k]), 16'd0);
            check_output($sformatf("reset op_count%0d", k), 16'(o_cnt[k]), 16'd0);
            check_output($sformatf("reset rsp_y%0d", k), 16'(o_y[k]), 16'd0);
        end
        rst = 1'b0;

        // Single operation: 3 + 5 on requester 0
        apply_stimulus(1, 4'h3, 4'h5, 3'd0, 0, 0, 4'h0, 4'h0, 3'd0, 0, 1);
        #1;
        check_output("single ready0", 16'(o_r0[0]), 16'd1);
        check_output("single ready1", 16'(o_r1[0]), 16'd0);
        tick();
        apply_stimulus(0, 4'h3, 4'h5, 3'd0, 0, 0, 4'h0, 4'h0, 3'd0, 0, 1);
        check_output("single alu0", 16'(o_alu[0]), 16'h350);
        check_output("single alu1", 16'(o_alu[1]), 16'h350);
        check_output("single rv0 early", 16'(o_rv[0]), 16'd0);
        tick();
        check_output("single rv0", 16'(o_rv[0]), 16'd1);
        check_output("single y0", 16'(o_y[0]), 16'd8);
        check_output("single id0", 16'(o_id[0]), 16'd0);
        check_output("settle3 rv after N+1", 16'(o_rv[1]), 16'd0);
        tick();
        check_output("single count0", 16'(o_cnt[0]), 16'd1);
        check_output("settle3 rv after N+2", 16'(o_rv[1]), 16'd0);
        check_output("settle3 alu held", 16'(o_alu[1]), 16'h350);
        tick();
        check_output("settle3 rv after N+3", 16'(o_rv[1]), 16'd1);
        check_output("settle3 y", 16'(o_y[1]), 16'd8);
        tick();
        check_output("settle3 count", 16'(o_cnt[1]), 16'd1);
        wait_idle(20);

        // Contention: both requesters held valid, grants must alternate from requester 0
        do_reset();
        apply_stimulus(1, 4'h1, 4'h2, 3'd0, 0, 1, 4'h7, 4'h3, 3'd1, 0, 1);
        n = 0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            tick();
            if (o_rv[0]) begin
                ids[n] = o_id[0];
                ys[n]  = o_y[0];
                n++;
            end
        end
        apply_stimulus(0, 4'h0, 4'h0, 3'd0, 0, 0, 4'h0, 4'h0, 3'd0, 0, 1);
        check_output("contention responses", 16'(n), 16'd4);
        for (int j = 0; j < 4 && j < n; j++) begin
            check_output($sformatf("contention id[%0d]", j), 16'(ids[j]), 16'(exp_id[j]));
            check_output($sformatf("contention y[%0d]", j), 16'(ys[j]), 16'(exp_y[j]));
        end
        tick();
        check_output("contention count", 16'(o_cnt[0]), 16'd4);
        wait_idle(50);

        // Back-pressure: result held while the consumer stalls
        apply_stimulus(1, 4'h9, 4'h4, 3'd4, 0, 1, 4'h2, 4'h2, 3'd3, 0, 0);
        tick();
        tick();
        check_output("bp rv", 16'(o_rv[0]), 16'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_output("bp rv held", 16'(o_rv[0]), 16'd1);
            check_output("bp y held", 16'(o_y[0]), 16'hD);
            check_output("bp id held", 16'(o_id[0]), 16'd0);
            check_output("bp alu held", 16'(o_alu[0]), 16'h948);
            check_output("bp readies", 16'({o_r0[0], o_r1[0]}), 16'd0);
            check_output("bp busy", 16'(o_busy[0]), 16'd1);
        end
        rr = 1'b1;
        tick();
        check_output("bp released rv", 16'(o_rv[0]), 16'd0);
        check_output("bp next ready1", 16'(o_r1[0]), 16'd1);
        check_output("bp next ready0", 16'(o_r0[0]), 16'd0);
        tick();
        check_output("bp next accept busy", 16'(o_busy[0]), 16'd1);
        check_output("bp next accept alu", 16'(o_alu[0]), 16'h226);
        apply_stimulus(0, 4'h0, 4'h0, 3'd0, 0, 0, 4'h0, 4'h0, 3'd0, 0, 1);
        wait_idle(50);

        // Reset while an operation is in flight
        apply_stimulus(1, 4'h3, 4'h5, 3'd0, 0, 0, 4'h0, 4'h0, 3'd0, 0, 1);
        tick();
        apply_stimulus(0, 4'h3, 4'h5, 3'd0, 0, 0, 4'h0, 4'h0, 3'd0, 0, 1);
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            check_output($sformatf("midreset rv%0d", k), 16'(o_rv[k]), 16'd0);
            check_output($sformatf("midreset busy%0d", k), 16'(o_busy[k]), 16'd0);
            check_output($sformatf("midreset alu%0d", k), 16'(o_alu[k]), 16'd0);
        end
        tick();
        rst = 1'b0;
        apply_stimulus(1, 4'h6, 4'h1, 3'd0, 0, 1, 4'h5, 4'h5, 3'd2, 0, 1);
        #1;
        check_output("post reset tie ready0", 16'(o_r0[0]), 16'd1);
        check_output("post reset tie ready1", 16'(o_r1[0]), 16'd0);
        check_output("post reset count", 16'(o_cnt[0]), 16'd0);
        apply_stimulus(0, 4'h6, 4'h1, 3'd0, 0, 0, 4'h5, 4'h5, 3'd2, 0, 1);
        tick();
        check_output("dropped valid busy", 16'(o_busy[0]), 16'd0);
        check_output("dropped valid alu", 16'(o_alu[0]), 16'd0);

        // op_count wraps after 256 completions
        do_reset();
        apply_stimulus(1, 4'h1, 4'h1, 3'd0, 0, 1, 4'h2, 4'h2, 3'd0, 0, 1);
        n = 0;
        for (int i = 0; i < 1200 && n < 256; i++) begin
            tick();
            if (o_rv[0]) n++;
        end
        check_output("wrap responses", 16'(n), 16'd256);
        check_output("wrap count 255", 16'(o_cnt[0]), 16'd255);
        apply_stimulus(0, 4'h0, 4'h0, 3'd0, 0, 0, 4'h0, 4'h0, 3'd0, 0, 1);
        tick();
        check_output("wrap count 0", 16'(o_cnt[0]), 16'd0);
        check_output("wrap rv", 16'(o_rv[0]), 16'd0);
        wait_idle(50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
